wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/wb_arb_fifo.sv | 68 ++++++
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the writeback-port arbiter: FSM state encoding and the
// buffered long-latency-unit result entry.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_PENDING = 2'd1,
      ARB_STARVE  = 2'd2
   } wb_arb_state_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } llu_entry_t;

   function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
      rd_onehot = 32'd1 << rd;
   endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// In-order buffer of LLU results with per-entry WAW squash and a hazard mask
// built from the entries that are still live.
module wb_arb_fifo
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  llu_entry_t    push_entry,
   input  logic          pop,
   input  logic          squash_en,
   input  logic [4:0]    squash_rd,
   output llu_entry_t    head,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic [31:0]   pending_mask
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   llu_entry_t    mem [DEPTH];

   // A slot's valid bit is cleared on pop, so valid alone means "occupied and live".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && mem[i].valid && mem[i].rd == squash_rd)
               mem[i].valid <= 1'b0;
         end
         if (pop) begin
            mem[rd_ptr].valid <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].valid) pending_mask = pending_mask | rd_onehot(mem[i].rd);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

endmodule

// File: rtl/wb_arbiter.sv
// Shares the single register-file write port between the pipeline and buffered
// LLU results, with starvation relief. Optional macro: WB_ARB_BYPASS_EN.
module wb_arbiter
   import pipeline_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        llu_valid,
   input  logic [4:0]  llu_rd,
   input  logic [31:0] llu_data,
   output logic        llu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd,
   output logic        wb_stall,
   output logic [31:0] pending_mask
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(STARVE_LIMIT + 1);

   wb_arb_state_t state, state_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [AW:0]   count, occ_nxt;
   llu_entry_t    head, push_entry;
   logic          empty, full, accept, push, pop, squash_en;
   logic          head_live, pipe_req, blocked, port_we;

   assign llu_ready  = !full;
   assign accept     = llu_valid && !full;
   assign push_entry = '{valid: 1'b1, rd: llu_rd, data: llu_data};
   assign head_live  = !empty && head.valid && (head.rd != 5'd0);
   assign pipe_req   = RegWriteW && (RdW != 5'd0);
   assign rf_we      = port_we && rst_n;

   wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push),
      .push_entry   (push_entry),
      .pop          (pop),
      .squash_en    (squash_en),
      .squash_rd    (RdW),
      .head         (head),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .pending_mask (pending_mask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Dead heads (squashed or x0) retire without the port, even beside a pipeline write.
   always_comb begin
      port_we   = 1'b0;
      rf_rd     = '0;
      rf_wd     = '0;
      pop       = 1'b0;
      push      = accept;
      squash_en = 1'b0;
      wb_stall  = 1'b0;
      blocked   = 1'b0;
      if (state == ARB_STARVE) begin
         wb_stall = 1'b1;
         pop      = !empty;
         if (head_live) begin
            port_we = 1'b1;
            rf_rd   = head.rd;
            rf_wd   = head.data;
         end
      end else if (pipe_req) begin
         port_we   = 1'b1;
         rf_rd     = RdW;
         rf_wd     = ResultW;
         squash_en = 1'b1;
         pop       = !empty && !head_live;
         blocked   = head_live;
      end else if (!empty) begin
         pop = 1'b1;
         if (head_live) begin
            port_we = 1'b1;
            rf_rd   = head.rd;
            rf_wd   = head.data;
         end
      end
`ifdef WB_ARB_BYPASS_EN
      else if (state == ARB_IDLE && accept && !RegWriteW) begin
         push = 1'b0;
         if (llu_rd != 5'd0) begin
            port_we = 1'b1;
            rf_rd   = llu_rd;
            rf_wd   = llu_data;
         end
      end
`endif
   end

   always_comb begin
      occ_nxt   = count + (AW + 1)'(push) - (AW + 1)'(pop);
      wait_nxt  = wait_cnt;
      state_nxt = (occ_nxt != '0) ? ARB_PENDING : ARB_IDLE;
      if (pop)
         wait_nxt = '0;
      else if (blocked)
         wait_nxt = wait_cnt + 1'b1;
      if (blocked && (wait_cnt + 1'b1) == WW'(STARVE_LIMIT))
         state_nxt = ARB_STARVE;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter in its default build (LLU bypass disabled).
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        llu_valid;
   logic [4:0]  llu_rd;
   logic [31:0] llu_data;
   logic        llu_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;
   logic        wb_stall;
   logic [31:0] pending_mask;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] rf_model [32];

   wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .RegWriteW    (RegWriteW),
      .RdW          (RdW),
      .ResultW      (ResultW),
      .llu_valid    (llu_valid),
      .llu_rd       (llu_rd),
      .llu_data     (llu_data),
      .llu_ready    (llu_ready),
      .rf_we        (rf_we),
      .rf_rd        (rf_rd),
      .rf_wd        (rf_wd),
      .wb_stall     (wb_stall),
      .pending_mask (pending_mask)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_we) rf_model[rf_rd] <= rf_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd);
      chk({tag, ".we"}, 32'(rf_we), 32'(we));
      if (we) begin
         chk({tag, ".rd"}, 32'(rf_rd), 32'(rd));
         chk({tag, ".wd"}, rf_wd, wd);
      end
   endtask

   task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      RegWriteW = rw;
      RdW       = rdw;
      ResultW   = resw;
      llu_valid = lv;
      llu_rd    = lrd;
      llu_data  = ld;
      #2;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rf_model[r] = '0;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("rst.we", 32'(rf_we), 32'd0);
      chk("rst.stall", 32'(wb_stall), 32'd0);
      chk("rst.mask", pending_mask, 32'd0);
      #10 rst_n = 1'b1;
      tick;
      chk("rel.ready", 32'(llu_ready), 32'd1);
      chk("rel.we", 32'(rf_we), 32'd0);

      // LLU result into idle arbiter: buffered, written next cycle
      drive(0, 0, 0, 1, 5'd5, 32'h1234);
      chk("a.ready", 32'(llu_ready), 32'd1);
      chk_wr("a.c0", 0, 0, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk_wr("a.c1", 1, 5'd5, 32'h1234);
      chk("a.mask", pending_mask, 32'h0000_0020);
      tick;
      chk_wr("a.c2", 0, 0, 0);
      chk("a.mask2", pending_mask, 32'd0);

      // Pipeline and LLU in the same cycle: pipeline first
      drive(1, 5'd3, 32'h11, 1, 5'd7, 32'hAA);
      chk_wr("b.n", 1, 5'd3, 32'h11);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk_wr("b.n1", 1, 5'd7, 32'hAA);
      chk("b.mask", pending_mask, 32'h0000_0080);
      tick;
      chk_wr("b.n2", 0, 0, 0);

      // Starvation: x9 buffered, x10 pipeline writes for 6 cycles
      drive(0, 0, 0, 1, 5'd9, 32'h99);
      tick;
      for (int i = 0; i < 6; i++) begin
         drive(1, 5'd10, 32'h100 + 32'(i), 0, 0, 0);
         if (i == 4) begin
            chk("c.stall", 32'(wb_stall), 32'd1);
            chk_wr("c.starve", 1, 5'd9, 32'h99);
         end else begin
            chk("c.nostall", 32'(wb_stall), 32'd0);
            chk_wr("c.pipe", 1, 5'd10, 32'h100 + 32'(i));
         end
         chk("c.mask", pending_mask, (i < 5) ? 32'h0000_0200 : 32'd0);
         tick;
      end
      drive(0, 0, 0, 0, 0, 0);
      chk_wr("c.done", 0, 0, 0);

      // WAW squash of buffered x12
      drive(0, 0, 0, 1, 5'd12, 32'h5);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("d.mask", pending_mask, 32'h0000_1000);
      drive(1, 5'd12, 32'h6, 0, 0, 0);
      chk_wr("d.pipe", 1, 5'd12, 32'h6);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("d.mask2", pending_mask, 32'd0);
      chk_wr("d.drop", 0, 0, 0);
      tick;
      chk("d.x12", rf_model[12], 32'h6);

      // Full buffer back-pressure with pops blocked by pipeline writes to x20
      drive(1, 5'd20, 32'h20, 1, 5'd13, 32'h13);
      chk("e.rdy0", 32'(llu_ready), 32'd1);
      tick;
      drive(1, 5'd20, 32'h21, 1, 5'd14, 32'h14);
      chk("e.rdy1", 32'(llu_ready), 32'd1);
      tick;
      drive(1, 5'd20, 32'h22, 1, 5'd15, 32'h15);
      chk("e.rdy_full", 32'(llu_ready), 32'd0);
      chk("e.mask", pending_mask, 32'h0000_6000);
      tick;
      drive(0, 0, 0, 1, 5'd15, 32'h15);
      chk("e.rdy_pop", 32'(llu_ready), 32'd0);
      chk_wr("e.w13", 1, 5'd13, 32'h13);
      tick;
      chk("e.rdy_after", 32'(llu_ready), 32'd1);
      chk_wr("e.w14", 1, 5'd14, 32'h14);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk_wr("e.w15", 1, 5'd15, 32'h15);
      tick;
      chk_wr("e.idle", 0, 0, 0);

      // x0 targets never reach the port
      drive(1, 5'd0, 32'hBEEF, 1, 5'd0, 32'hDEAD);
      chk_wr("f.pipe_x0", 0, 0, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk_wr("f.llu_x0", 0, 0, 0);
      tick;
      chk("f.ready", 32'(llu_ready), 32'd1);
      chk("f.mask", pending_mask, 32'd0);

      // Reset while starving with two entries buffered
      drive(1, 5'd22, 32'h30, 1, 5'd21, 32'h21);
      tick;
      drive(1, 5'd22, 32'h31, 1, 5'd23, 32'h23);
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd22, 32'h32, 0, 0, 0);
         tick;
      end
      chk("g.stall", 32'(wb_stall), 32'd1);
      chk("g.mask", pending_mask, 32'h00A0_0000);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk("g.rst.we", 32'(rf_we), 32'd0);
      chk("g.rst.stall", 32'(wb_stall), 32'd0);
      chk("g.rst.mask", pending_mask, 32'd0);
      tick;
      rst_n = 1'b1;
      #2;
      chk("g.rel.we", 32'(rf_we), 32'd0);
      chk("g.rel.ready", 32'(llu_ready), 32'd1);
      tick;
      chk("g.rel.we2", 32'(rf_we), 32'd0);
      chk("g.rel.stall", 32'(wb_stall), 32'd0);

      chk("rf.x3", rf_model[3], 32'h11);
      chk("rf.x7", rf_model[7], 32'hAA);
      chk("rf.x9", rf_model[9], 32'h99);
      chk("rf.x10", rf_model[10], 32'h105);
      chk("rf.x0", rf_model[0], 32'd0);
      chk("rf.x21", rf_model[21], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
